// File: rtl/sort_net_pkg.sv
// Shared constants and helpers for the sort_net_pipe sorting network.
package sort_net_pkg;

  localparam string SORT_UP   = "UP";
  localparam string SORT_DOWN = "DOWN";

  // Bit offset of lane 'lane' in a flat vector of 'w'-bit lanes.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cmp_swap_cell.sv
// Two-lane combinational compare-exchange; signed compare when SORT_NET_PIPE_SIGNED_EN is defined.
module cmp_swap_cell
  import sort_net_pkg::*;
#(
  parameter int    DATA_WIDTH = 64,
  parameter string COM_STYLE  = "UP"
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic [DATA_WIDTH-1:0] hi_o
);

  logic lt;
  logic swap;

`ifdef SORT_NET_PIPE_SIGNED_EN
  assign lt = $signed(a_i) < $signed(b_i);
`else
  assign lt = a_i < b_i;
`endif

  // UP keeps the larger value in the lower lane; DOWN keeps the smaller one there.
  assign swap = (COM_STYLE == SORT_UP) ? lt : !lt;
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort_net_pipe.sv
// Pipelined odd-even transposition sort of NUM_CH lanes, valid/ready on both sides.
// Build option: SORT_NET_PIPE_SIGNED_EN selects two's-complement lane comparison.
module sort_net_pipe
  import sort_net_pkg::*;
#(
  parameter int    DATA_WIDTH = 64,
  parameter int    NUM_CH     = 8,
  parameter string COM_STYLE  = "UP"
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [clog2(NUM_CH+1)-1:0]     occupancy
);

  localparam int OCC_W = clog2(NUM_CH + 1);

  if ((COM_STYLE != SORT_UP) && (COM_STYLE != SORT_DOWN)) begin : g_bad_style
    $error("sort_net_pipe: COM_STYLE must be \"UP\" or \"DOWN\"");
  end
  if ((NUM_CH < 2) || (NUM_CH % 2 != 0)) begin : g_bad_ch
    $error("sort_net_pipe: NUM_CH must be even and >= 2");
  end

  typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t [NUM_CH-1:0] stg_q, stg_d;
  vec_t [NUM_CH-1:0] stg_in;
  vec_t [NUM_CH-1:0] cx;
  logic [NUM_CH-1:0] vld_q, vld_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              adv;

  assign adv     = m_ready || !m_valid;
  assign s_ready = adv;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_in
    assign stg_in[0][i] = s_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stg_in[k] = stg_q[k-1];
    end
    if (k % 2 == 0) begin : g_even
      for (genvar p = 0; p < NUM_CH/2; p++) begin : g_pair
        cmp_swap_cell #(.DATA_WIDTH(DATA_WIDTH), .COM_STYLE(COM_STYLE)) u_cell (
          .a_i  (stg_in[k][2*p]),
          .b_i  (stg_in[k][2*p+1]),
          .lo_o (cx[k][2*p]),
          .hi_o (cx[k][2*p+1])
        );
      end
    end else begin : g_odd
      // Edge lanes have no partner on odd layers.
      assign cx[k][0]        = stg_in[k][0];
      assign cx[k][NUM_CH-1] = stg_in[k][NUM_CH-1];
      for (genvar p = 0; p < NUM_CH/2-1; p++) begin : g_pair
        cmp_swap_cell #(.DATA_WIDTH(DATA_WIDTH), .COM_STYLE(COM_STYLE)) u_cell (
          .a_i  (stg_in[k][2*p+1]),
          .b_i  (stg_in[k][2*p+2]),
          .lo_o (cx[k][2*p+1]),
          .hi_o (cx[k][2*p+2])
        );
      end
    end
  end

  // Single global enable: bubbles shift like beats, nothing collapses.
  always_comb begin
    stg_d = stg_q;
    vld_d = vld_q;
    if (adv) begin
      stg_d = cx;
      vld_d = {vld_q[NUM_CH-2:0], s_valid};
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_CH; i++) occ_d = occ_d + OCC_W'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      stg_q <= stg_d;
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign m_data    = stg_q[NUM_CH-1];
  assign m_valid   = vld_q[NUM_CH-1];
  assign occupancy = occ_q;

endmodule
